dwpe_array_acc: RTL



---
 rtl/dwpe_array_acc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dwpe_array_acc.sv
// rtl/dwpe_array_acc.sv - depthwise PE array: per-row weighted window accumulation, bias, ReLU, rescale/saturate
module dwpe_array_acc #(
   parameter  int DW    = 16,
   parameter  int POX   = 16,
   parameter  int POY   = 3,
   parameter  int KMAX  = 9,
   parameter  int ACC_W = 2*DW+4,
   parameter  int FRAC  = 8,
   localparam int KW    = $clog2(KMAX+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] pixel_array [POY][POX],
   input  logic signed [DW-1:0] weight [POY],
   input  logic signed [DW-1:0] bias [POY],
   input  logic [KW-1:0]        kk,
   input  logic                 relu_en,
   input  logic                 clear,
   output logic signed [DW-1:0] result [POY][POX],
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic [KW-1:0]        tap_q, tap_d;
   logic [KW-1:0]        kk_q, kk_d;
   logic                 relu_q, relu_d;
   logic                 out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] acc_q [POY][POX];
   logic signed [ACC_W-1:0] acc_d [POY][POX];
   logic signed [DW-1:0]    res_q [POY][POX];
   logic signed [DW-1:0]    res_d [POY][POX];

   logic [KW-1:0] kk_new;
   logic          last_tap;
   logic          relu_eff;
   logic          accept;

   // Rescale, optional ReLU and clamp of a finished accumulator
   function automatic logic signed [DW-1:0] sat_fn(input logic signed [ACC_W-1:0] a,
                                                   input logic relu);
      logic signed [ACC_W-1:0] v;
      v = a >>> FRAC;
      if (relu && v[ACC_W-1]) v = '0;
      if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
      else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
      else                  return v[DW-1:0];
   endfunction

   // Window length for a window that would start on this beat (0 means one tap)
   always_comb begin
      kk_new = kk;
      if (kk == '0)              kk_new = KW'(1);
      else if (kk > KW'(KMAX))   kk_new = KW'(KMAX);
   end

   // The final tap is the only beat that can be stalled by a held result
   always_comb begin
      last_tap = (tap_q == '0) ? (kk_new == KW'(1)) : (tap_q == kk_q - KW'(1));
      relu_eff = (tap_q == '0) ? relu_en : relu_q;
      in_ready = !clear && !(last_tap && out_valid_q && !out_ready);
      accept   = in_valid && in_ready;
   end

   // Next-state: accumulation, tap counting and output-stage load/drain
   always_comb begin
      logic signed [ACC_W-1:0] base;
      logic signed [2*DW-1:0]  prod;
      tap_d       = tap_q;
      kk_d        = kk_q;
      relu_d      = relu_q;
      acc_d       = acc_q;
      res_d       = res_q;
      out_valid_d = out_valid_q;
      base        = '0;
      prod        = '0;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (clear) begin
         tap_d = '0;
         acc_d = '{default: '0};
      end else if (accept) begin
         if (tap_q == '0) begin
            kk_d   = kk_new;
            relu_d = relu_en;
         end
         for (int r = 0; r < POY; r++) begin
            for (int c = 0; c < POX; c++) begin
               prod = (2*DW)'(pixel_array[r][c]) * (2*DW)'(weight[r]);
               base = (tap_q == '0) ? (ACC_W'(bias[r]) <<< FRAC) : acc_q[r][c];
               acc_d[r][c] = base + ACC_W'(prod);
               if (last_tap) res_d[r][c] = sat_fn(acc_d[r][c], relu_eff);
            end
         end
         if (last_tap) begin
            tap_d       = '0;
            out_valid_d = 1'b1;
         end else begin
            tap_d = tap_q + KW'(1);
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_q       <= '0;
         kk_q        <= '0;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
         acc_q       <= '{default: '0};
         res_q       <= '{default: '0};
      end else begin
         tap_q       <= tap_d;
         kk_q        <= kk_d;
         relu_q      <= relu_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
      end
   end

   assign result    = res_q;
   assign out_valid = out_valid_q;
   assign busy      = (tap_q != '0);

endmodule
